// File: rtl/run_length_detector.sv
// Streaming run detector: flags beats that complete/extend a run of RUN_LEN equal symbols.
// Optional RUN_DETECT_MATCH_EN: only symbols equal to MATCH_VAL contribute to a run.
module run_length_detector #(
  parameter int                DATA_W    = 1,
  parameter int                RUN_LEN   = 2,
  parameter logic [DATA_W-1:0] MATCH_VAL = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_valid,
  input  logic              i_sop,
  input  logic              i_eop,
  input  logic [DATA_W-1:0] inp,
  output logic              i_ready,
  output logic              o_valid,
  output logic              o_sop,
  output logic              o_eop,
  output logic [DATA_W-1:0] o_data,
  output logic              outp,
  output logic              o_pkt_hit,
  input  logic              o_ready
);

  localparam int               CNT_W   = $clog2(RUN_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RUN_LEN);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_IN_PKT = 1'b1;

  logic [0:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] prev;
  logic              hit;

  logic              accept;
  logic              forward;
  logic [CNT_W-1:0]  cnt_next;
  logic              run_hit;
  logic              hit_base;
`ifdef RUN_DETECT_MATCH_EN
  logic [CNT_W-1:0]  cnt_base;
`endif

  assign i_ready = reset_n & (~o_valid | o_ready);
  assign accept  = i_valid & i_ready;
  // Non-sop beats in IDLE are consumed but never reach the output register.
  assign forward = accept & (i_sop | (state == ST_IN_PKT));

  always_comb begin
    cnt_next = '0;
`ifdef RUN_DETECT_MATCH_EN
    cnt_base = i_sop ? '0 : cnt;
    if (inp == MATCH_VAL) begin
      cnt_next = (cnt_base == CNT_MAX) ? CNT_MAX : cnt_base + 1'b1;
    end
`else
    if (i_sop || (inp != prev)) begin
      cnt_next = CNT_W'(1);
    end else begin
      cnt_next = (cnt == CNT_MAX) ? CNT_MAX : cnt + 1'b1;
    end
`endif
    run_hit  = (cnt_next == CNT_MAX);
    hit_base = i_sop ? 1'b0 : hit;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      prev      <= '0;
      hit       <= 1'b0;
      o_valid   <= 1'b0;
      o_sop     <= 1'b0;
      o_eop     <= 1'b0;
      o_data    <= '0;
      outp      <= 1'b0;
      o_pkt_hit <= 1'b0;
    end else begin
      if (o_valid && o_ready) begin
        o_valid <= 1'b0;
      end
      if (forward) begin
        o_valid   <= 1'b1;
        o_sop     <= i_sop;
        o_eop     <= i_eop;
        o_data    <= inp;
        outp      <= run_hit;
        o_pkt_hit <= i_eop & (hit_base | run_hit);
        cnt       <= cnt_next;
        prev      <= inp;
        hit       <= hit_base | run_hit;
        state     <= i_eop ? ST_IDLE : ST_IN_PKT;
      end
    end
  end

endmodule

// File: tb/tb_run_length_detector.sv
// Scoreboard bench for run_length_detector (DATA_W=4, RUN_LEN=3): driver pushes
// hand-computed expectations at accept time, an independent monitor pops on each output handshake.
module tb_run_length_detector;

  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          i_valid = 1'b0, i_sop = 1'b0, i_eop = 1'b0;
  logic [DW-1:0] inp = '0;
  logic          i_ready;
  logic          o_valid, o_sop, o_eop, outp, o_pkt_hit;
  logic [DW-1:0] o_data;
  logic          o_ready = 1'b1;

  run_length_detector #(
    .DATA_W   (DW),
    .RUN_LEN  (3),
    .MATCH_VAL(4'h1)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_valid  (i_valid),
    .i_sop    (i_sop),
    .i_eop    (i_eop),
    .inp      (inp),
    .i_ready  (i_ready),
    .o_valid  (o_valid),
    .o_sop    (o_sop),
    .o_eop    (o_eop),
    .o_data   (o_data),
    .outp     (outp),
    .o_pkt_hit(o_pkt_hit),
    .o_ready  (o_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          sop;
    logic          eop;
    logic [DW-1:0] data;
    logic          outp;
    logic          hit;
    int            cyc;
  } beat_t;

  beat_t exp_q[$];
  int    compared = 0;
  int    mismatched = 0;
  int    cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one beat; fwd=1 means the beat must appear downstream with the given flags.
  task automatic send(input logic s, input logic e, input logic [DW-1:0] d,
                      input logic fwd, input logic o, input logic h);
    int n = 0;
    beat_t b;
    @(negedge clk);
    i_valid = 1'b1; i_sop = s; i_eop = e; inp = d;
    #1;
    while (!i_ready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (!i_ready) chk("accept_timeout", 32'd0, 32'd1);
    if (fwd) begin
      b.sop = s; b.eop = e; b.data = d; b.outp = o; b.hit = h; b.cyc = cyc;
      exp_q.push_back(b);
    end
    @(posedge clk);
    #1 i_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic stall(input int n);
    #1 o_ready = 1'b0;
    fork
      begin
        repeat (n) @(posedge clk);
        #2 o_ready = 1'b1;
      end
    join_none
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_o_valid"}, 32'(o_valid), 32'd0);
    chk({tag, "_o_sop"}, 32'(o_sop), 32'd0);
    chk({tag, "_o_eop"}, 32'(o_eop), 32'd0);
    chk({tag, "_o_data"}, 32'(o_data), 32'd0);
    chk({tag, "_outp"}, 32'(outp), 32'd0);
    chk({tag, "_o_pkt_hit"}, 32'(o_pkt_hit), 32'd0);
    chk({tag, "_i_ready"}, 32'(i_ready), 32'd0);
  endtask

  logic          stalled = 1'b0;
  int            first_seen = 0;
  logic [DW+3:0] snap;

  always @(negedge clk) begin
    beat_t b;
    if (!reset_n) begin
      chk("i_ready_in_reset", 32'(i_ready), 32'd0);
      stalled = 1'b0;
    end else if (o_valid) begin
      if (!stalled) first_seen = cyc;
      else chk("stall_hold", 32'({o_sop, o_eop, o_data, outp, o_pkt_hit}), 32'(snap));
      if (o_ready) begin
        stalled = 1'b0;
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 32'(o_data), 32'hDEAD);
        end else begin
          b = exp_q.pop_front();
          chk("o_sop", 32'(o_sop), 32'(b.sop));
          chk("o_eop", 32'(o_eop), 32'(b.eop));
          chk("o_data", 32'(o_data), 32'(b.data));
          chk("outp", 32'(outp), 32'(b.outp));
          chk("o_pkt_hit", 32'(o_pkt_hit), 32'(b.hit));
          chk("latency", 32'(first_seen), 32'(b.cyc + 1));
        end
      end else begin
        chk("i_ready_stalled", 32'(i_ready), 32'd0);
        snap = {o_sop, o_eop, o_data, outp, o_pkt_hit};
        stalled = 1'b1;
      end
    end else begin
      chk("i_ready_empty", 32'(i_ready), 32'd1);
      stalled = 1'b0;
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 chk_zero("reset");
    @(negedge clk); #1 reset_n = 1'b1;

`ifdef RUN_DETECT_MATCH_EN
    // MATCH_VAL=1: count only 1s, non-matching symbol clears the count
    send(1, 0, 4'h0, 1, 0, 0);
    send(0, 0, 4'h0, 1, 0, 0);
    send(0, 0, 4'h1, 1, 0, 0);
    send(0, 0, 4'h1, 1, 0, 0);
    send(0, 0, 4'h1, 1, 1, 0);
    send(0, 1, 4'h1, 1, 1, 1);
    send(1, 0, 4'h1, 1, 0, 0);
    send(0, 0, 4'h1, 1, 0, 0);
    stall(3);
    send(0, 0, 4'h0, 1, 0, 0);
    send(0, 1, 4'h1, 1, 0, 0);
    send(1, 0, 4'h1, 1, 0, 0);
    idle(2);
    send(0, 0, 4'h1, 1, 0, 0);
    send(0, 1, 4'h1, 1, 1, 1);
`else
    // Run of four A saturates at RUN_LEN, then B,B
    send(1, 0, 4'hA, 1, 0, 0);
    send(0, 0, 4'hA, 1, 0, 0);
    send(0, 0, 4'hA, 1, 1, 0);
    send(0, 0, 4'hA, 1, 1, 0);
    send(0, 0, 4'hB, 1, 0, 0);
    send(0, 1, 4'hB, 1, 0, 1);
    // New packet B,B: the previous packet's run must not carry over
    send(1, 0, 4'hB, 1, 0, 0);
    send(0, 1, 4'hB, 1, 0, 0);
    // Backpressure plus a bubble inside a run
    send(1, 0, 4'h5, 1, 0, 0);
    send(0, 0, 4'h5, 1, 0, 0);
    stall(3);
    idle(2);
    send(0, 0, 4'h5, 1, 1, 0);
    send(0, 0, 4'h5, 1, 1, 0);
    send(0, 1, 4'h6, 1, 0, 1);
    // Mid-packet sop restarts run state and clears hit
    send(1, 0, 4'h9, 1, 0, 0);
    send(0, 0, 4'h9, 1, 0, 0);
    send(0, 0, 4'h9, 1, 1, 0);
    send(1, 1, 4'h9, 1, 0, 0);
`endif
    // Non-sop beats in IDLE are dropped; then a single-beat packet
    send(0, 0, 4'h5, 0, 0, 0);
    send(0, 0, 4'h5, 0, 0, 0);
    send(1, 1, 4'h7, 1, 0, 0);

    // Reset two beats into a packet
    send(1, 0, 4'h3, 1, 0, 0);
    send(0, 0, 4'h3, 1, 0, 0);
    @(negedge clk); #1 reset_n = 1'b0;
    @(posedge clk); #1 chk_zero("midreset");
    @(negedge clk); #1 reset_n = 1'b1;
    send(0, 0, 4'h3, 0, 0, 0);
`ifdef RUN_DETECT_MATCH_EN
    send(1, 0, 4'h1, 1, 0, 0);
    send(0, 0, 4'h1, 1, 0, 0);
    send(0, 1, 4'h1, 1, 1, 1);
`else
    send(1, 0, 4'h3, 1, 0, 0);
    send(0, 0, 4'h3, 1, 0, 0);
    send(0, 1, 4'h3, 1, 1, 1);
`endif
    idle(5);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
